// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the divider issuer.
package divider_pkg;

    localparam int OP_W = 4;
    localparam int Q_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } issuer_state_e;

endpackage

// File: rtl/divider_issuer.sv
// Initiator side of the divider start/busy/finish handshake.
// Takes operand pairs over a valid/ready request port, pulses start to the
// divider, waits for a fresh finish (or times out) and returns the quotient
// over a valid/ready response port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; operands latched on handshake
// START | div_start_o high for START_LEN cycles, operands frozen
// WAIT  | waiting for a finish that follows the arming condition, or timeout
// RESP  | response held on rsp_* until the consumer takes it
module divider_issuer #(
    parameter int OP_W      = divider_pkg::OP_W,
    parameter int Q_W       = divider_pkg::Q_W,
    parameter int START_LEN = 1,
    parameter int TIMEOUT   = 63
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [OP_W-1:0] req_dividend_i,
    input  logic [OP_W-1:0] req_divisor_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [Q_W-1:0]  rsp_quotient_o,
    output logic            rsp_timeout_o,
    output logic [OP_W-1:0] div_dividend_o,
    output logic [OP_W-1:0] div_divisor_o,
    output logic            div_start_o,
    input  logic            div_busy_i,
    input  logic            div_finish_i,
    input  logic [Q_W-1:0]  div_quotient_i,
    output logic [7:0]      ops_done_o
);
    import divider_pkg::*;

    localparam int SL_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [SL_W-1:0] START_LAST = SL_W'(START_LEN - 1);
    localparam logic [TO_W-1:0] WAIT_LAST  = TO_W'(TIMEOUT - 1);

    issuer_state_e   state_q, state_d;
    logic [SL_W-1:0] start_cnt_q, start_cnt_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            armed_q, armed_d;
    logic [OP_W-1:0] dividend_q, dividend_d;
    logic [OP_W-1:0] divisor_q, divisor_d;
    logic [Q_W-1:0]  quot_q, quot_d;
    logic            timeout_q, timeout_d;
    logic [7:0]      ops_done_q, ops_done_d;

    // A finish level seen before the divider has shown it noticed the new
    // start (finish low or busy high) belongs to the previous operation.
    logic            arm_cond;
    assign arm_cond = !div_finish_i || div_busy_i;

    // State register and all datapath registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
            armed_q     <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quot_q      <= '0;
            timeout_q   <= 1'b0;
            ops_done_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            armed_q     <= armed_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quot_q      <= quot_d;
            timeout_q   <= timeout_d;
            ops_done_q  <= ops_done_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        armed_d     = armed_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quot_d      = quot_q;
        timeout_d   = timeout_q;
        ops_done_d  = ops_done_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        div_start_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    dividend_d  = req_dividend_i;
                    divisor_d   = req_divisor_i;
                    armed_d     = 1'b0;
                    start_cnt_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = START;
                end
            end
            START: begin
                div_start_o = 1'b1;
                if (arm_cond) begin
                    armed_d = 1'b1;
                end
                if (start_cnt_q == START_LAST) begin
                    state_d = WAIT;
                end else begin
                    start_cnt_d = start_cnt_q + SL_W'(1);
                end
            end
            WAIT: begin
                if (arm_cond) begin
                    armed_d = 1'b1;
                end
                // A genuine finish beats the timeout on the same cycle.
                if (armed_q && div_finish_i) begin
                    quot_d    = div_quotient_i;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    quot_d    = '1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    ops_done_d = ops_done_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_quotient_o = quot_q;
    assign rsp_timeout_o  = timeout_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign ops_done_o     = ops_done_q;

endmodule
